eth_mii_rx_unpack: RTL
======================

Name: eth_mii_rx_unpack

Overview:
- Receive-side MII framer. Strips preamble/SFD, packs 4-bit MII nibbles into DATA_W-bit little-endian words, runs Ethernet CRC-32 and flags the last beat with per-frame status.
- Sits between the PHY MII receive pins and a user or DMA sink. This is the parametrised, CRC-checking successor to the fixed MII receive path feeding the TSE MAC.
- No backpressure: MII cannot stall, so every word is emitted as a single-cycle strobe.

Parameters:
- DATA_W, 32: output word width; legal values 8, 16, 32.
- MAX_FRAME_BYTES, 1518: bytes beyond this count (FCS included) are dropped and too_long is set.
- MIN_FRAME_BYTES, 64: frames shorter than this (FCS included) set too_short.
- MIN_PREAMBLE_NIB, 7: minimum number of 0x5 nibbles required before the SFD nibble 0xD.
- CRC_CHECK, 1: 1 = compute CRC and report crc_ok; 0 = crc_ok is constant 1 and no CRC logic is built.

Ports:
- sys_clk  in  1  MII receive clock; all logic is in this domain.
- sys_rst  in  1  asynchronous, active-high reset.
- mii_rx_dv  in  1  MII receive data valid.
- mii_rx_er  in  1  MII receive error.
- mii_rx_d  in  4  MII receive nibble; the low nibble of each byte arrives first.
- out_valid  out  1  one-cycle strobe: out_data is valid.
- out_data  out  DATA_W  packed word; byte 0 is in bits [7:0].
- out_keep  out  DATA_W/8  byte-valid mask; all ones except possibly on the last beat.
- out_last  out  1  final beat of the frame.
- out_len  out  16  frame byte count (FCS included, saturates at MAX_FRAME_BYTES); valid when out_last=1.
- out_status  out  5  {dribble, rx_err, too_long, too_short, crc_ok}; valid when out_last=1, 0 on other beats.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters, holding register and CRC cleared. Reset asserted mid-frame abandons the frame and no last beat is produced.
- FSM states: IDLE, PREAMBLE, DATA, DISCARD.
- IDLE:
  - rx_dv=1 and d=0x5 -> PREAMBLE, preamble count=1.
  - rx_dv=1 and any other nibble -> DISCARD.
- PREAMBLE:
  - d=0x5: count++ (saturates at 15).
  - d=0xD and count>=MIN_PREAMBLE_NIB -> DATA; CRC seeded to 0xFFFFFFFF; byte count and nibble phase cleared.
  - d=0xD with too short a count, or any other nibble -> DISCARD.
  - rx_dv=0 -> IDLE; nothing is emitted.
- DISCARD: ignores input until rx_dv=0, then -> IDLE; nothing is emitted.
- DATA, nibble assembly:
  - Phase 0 latches the low nibble; phase 1 completes the byte.
  - The completed byte goes into lane (byte_count mod DATA_W/8) of the assembly word; byte_count++ if below MAX_FRAME_BYTES, otherwise the byte is dropped and too_long is set.
- DATA, CRC: updated every nibble, reflected polynomial 0x04C11DB7, LSB first. At end of frame crc_ok = (CRC register == 0xC704DD7B residue).
- DATA, word release:
  - A full assembly word moves to a holding register.
  - The held word is emitted (out_valid=1, out_last=0, keep all ones) in the cycle after the first byte of the next word completes.
  - This one-word delay exists so the true final word can carry out_last.
- Errors: rx_er=1 with rx_dv=1 in DATA latches rx_err for the frame.
- End of frame (rx_dv falls in DATA):
  - If phase=1 (odd nibble), set dribble and discard the half byte.
  - Next cycle emit the final beat: the partial assembly word if non-empty (keep = low n lanes), otherwise the held word (keep all ones), with out_last=1 and out_len/out_status populated.
  - If any full word is held while a partial word is also pending, the held word is emitted first and the partial word follows with out_last=1 one cycle later. Return to IDLE happens after the last beat.
  - Frames ending with zero bytes after the SFD emit nothing.
- too_short = byte_count < MIN_FRAME_BYTES, evaluated at end of frame.
- rx_dv rising in the same cycle the last beat issues is handled as a fresh IDLE start; the FSM must accept a new preamble nibble in the cycle after DATA exits.
- Throughput: at most 1 word per 2*DATA_W/8 cycles; out_valid is never asserted on back-to-back cycles except for the held+partial pair.

Decomposition:
- Shared package eth_pkg: CRC32_POLY_REFL=32'hEDB88320, CRC32_RESIDUE=32'hC704DD7B, PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, status bit index constants, FSM state enum.
- Sub-module crc32_nib: combinational next-CRC for a 4-bit input, instantiated only when CRC_CHECK=1.

Test Plan:
- DATA_W=32: 7×0x5, 0xD, 64-byte frame with correct FCS -> 16 beats, last keep=4'b1111, out_len=64, out_status=5'b00001.
- DATA_W=32: 61-byte frame, good FCS -> 16 beats, last keep=4'b0001, out_len=61, status=5'b00011 (too_short, crc_ok).
- 64-byte frame with one data bit flipped -> crc_ok=0; rx_er pulsed mid-frame -> rx_err=1. Data beats are unchanged in both cases.
- Preamble of 5×0x5 then 0xD (MIN=7) -> no out_valid for the whole frame; the next good frame is received normally.
- 1600-byte frame with MAX=1518 -> out_len=1518, too_long=1, exactly 380 data beats for DATA_W=32. Plus an odd nibble at the end of a 64-byte frame -> dribble=1, out_len=64.
- sys_rst asserted after 20 bytes of a frame -> out_valid stays 0 and no last beat. A frame starting 2 cycles after reset release is received with correct status.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, types and helpers for the MII receive framer.
package eth_pkg;

  // Ethernet CRC-32, reflected form for LSB-first shifting.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Good-frame residue, expressed in MSB-first bit order.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // Bit positions inside out_status.
  localparam int ST_CRC_OK    = 0;
  localparam int ST_TOO_SHORT = 1;
  localparam int ST_TOO_LONG  = 2;
  localparam int ST_RX_ERR    = 3;
  localparam int ST_DRIBBLE   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DISCARD
  } rx_state_e;

  // The LSB-first CRC register holds the residue bit-reversed relative to
  // CRC32_RESIDUE, so comparisons go through this helper.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_nib.sv
// Combinational next-state of the Ethernet CRC-32 for one 4-bit nibble,
// bits consumed LSB first.
module crc32_nib
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  logic [31:0] crc;

  // Four serial LSB-first shift steps unrolled into one combinational stage.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    crc = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (crc[0] ^ nib[i]) crc = (crc >> 1) ^ CRC32_POLY_REFL;
      else                 crc = crc >> 1;
    end
    crc_out = crc;
  end

endmodule

// File: rtl/eth_mii_rx_unpack.sv
// MII receive framer: strips preamble/SFD, packs nibbles into little-endian
// DATA_W words, checks CRC-32 and tags the last beat with frame status.
module eth_mii_rx_unpack
  import eth_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int MAX_FRAME_BYTES  = 1518,
  parameter int MIN_FRAME_BYTES  = 64,
  parameter int MIN_PREAMBLE_NIB = 7,
  parameter int CRC_CHECK        = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                mii_rx_dv,
  input  logic                mii_rx_er,
  input  logic [3:0]          mii_rx_d,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic [15:0]         out_len,
  output logic [4:0]          out_status
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [15:0]       MAX_BYTES = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0]       MIN_BYTES = 16'(MIN_FRAME_BYTES);
  localparam logic [3:0]        MIN_PRE   = 4'(MIN_PREAMBLE_NIB);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  rx_state_e state, state_next;

  // FSM control strobes
  logic pre_start, pre_inc, sfd_hit, nib_en, eof;

  // Frame assembly state
  logic [3:0]        pre_cnt;
  logic              phase;
  logic [3:0]        low_nib;
  logic [15:0]       byte_cnt;
  logic [DATA_W-1:0] asm_data, asm_next, hold_data;
  logic              hold_valid;
  logic              rx_err_q, too_long_q;

  // Derived per-cycle values
  logic [LANE_W-1:0] lane;
  logic [7:0]        cur_byte;
  logic              byte_done, byte_drop;
  logic [LANES-1:0]  part_keep;
  logic [4:0]        fin_status;
  logic              crc_ok;

  // Deferred final beat for the held+partial pair
  logic              pend_valid;
  logic [DATA_W-1:0] pend_data;
  logic [LANES-1:0]  pend_keep;
  logic [15:0]       pend_len;
  logic [4:0]        pend_status;

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next-state decode from rx_dv and the incoming nibble.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mii_rx_dv) begin
          if (mii_rx_d == PREAMBLE_NIB) state_next = S_PREAMBLE;
          else                          state_next = S_DISCARD;
        end
      end
      S_PREAMBLE: begin
        if (!mii_rx_dv)                                    state_next = S_IDLE;
        else if (mii_rx_d == PREAMBLE_NIB)                 state_next = S_PREAMBLE;
        else if (mii_rx_d == SFD_NIB && pre_cnt >= MIN_PRE) state_next = S_DATA;
        else                                               state_next = S_DISCARD;
      end
      S_DATA:    if (!mii_rx_dv) state_next = S_IDLE;
      S_DISCARD: if (!mii_rx_dv) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: single-cycle strobes that steer the datapath.
  always_comb begin
    pre_start = 1'b0;
    pre_inc   = 1'b0;
    sfd_hit   = 1'b0;
    nib_en    = 1'b0;
    eof       = 1'b0;
    case (state)
      S_IDLE: pre_start = mii_rx_dv && (mii_rx_d == PREAMBLE_NIB);
      S_PREAMBLE: begin
        pre_inc = mii_rx_dv && (mii_rx_d == PREAMBLE_NIB);
        sfd_hit = mii_rx_dv && (mii_rx_d == SFD_NIB) && (pre_cnt >= MIN_PRE);
      end
      S_DATA: begin
        nib_en = mii_rx_dv;
        eof    = !mii_rx_dv;
      end
      default: ;
    endcase
  end

  assign cur_byte  = {mii_rx_d, low_nib};
  assign byte_done = nib_en && phase;
  assign byte_drop = (byte_cnt >= MAX_BYTES);
  assign lane      = (LANES > 1) ? byte_cnt[LANE_W-1:0] : '0;

  // Assembly word with the byte completing this cycle merged into its lane.
  always_comb begin
    asm_next = asm_data;
    asm_next[int'(lane)*8 +: 8] = cur_byte;
  end

  // At end of frame lane equals the number of bytes in the partial word.
  always_comb begin
    for (int i = 0; i < LANES; i++) part_keep[i] = (i < int'(lane));
  end

  // Frame status as it stands at end of frame.
  always_comb begin
    fin_status               = '0;
    fin_status[ST_CRC_OK]    = crc_ok;
    fin_status[ST_TOO_SHORT] = (byte_cnt < MIN_BYTES);
    fin_status[ST_TOO_LONG]  = too_long_q;
    fin_status[ST_RX_ERR]    = rx_err_q;
    fin_status[ST_DRIBBLE]   = phase;
  end

  // Preamble nibble counter, saturating at 15.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                          pre_cnt <= '0;
    else if (pre_start)                   pre_cnt <= 4'd1;
    else if (pre_inc && pre_cnt != 4'hF)  pre_cnt <= pre_cnt + 4'd1;
  end

  // Nibble-to-byte assembly, lane packing and the one-word holding register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: datapath registers are reset as well so no stale word survives a reset.
    if (sys_rst) begin
      phase      <= 1'b0;
      low_nib    <= '0;
      byte_cnt   <= '0;
      asm_data   <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      rx_err_q   <= 1'b0;
      too_long_q <= 1'b0;
    end else if (sfd_hit) begin
      phase      <= 1'b0;
      byte_cnt   <= '0;
      asm_data   <= '0;
      hold_valid <= 1'b0;
      rx_err_q   <= 1'b0;
      too_long_q <= 1'b0;
    end else if (nib_en) begin
      phase <= ~phase;
      if (mii_rx_er) rx_err_q <= 1'b1;
      if (!phase) begin
        low_nib <= mii_rx_d;
      end else if (byte_drop) begin
        too_long_q <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt + 16'd1;
        asm_data <= asm_next;
        if (lane == LAST_LANE) begin
          hold_data  <= asm_next;
          hold_valid <= 1'b1;
        end else if (lane == '0) begin
          hold_valid <= 1'b0;
        end
      end
    end else if (eof) begin
      hold_valid <= 1'b0;
    end
  end

  // Output beats: held word on the next word's first byte, tail beat(s) at end of frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
      out_last    <= 1'b0;
      out_len     <= '0;
      out_status  <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_keep   <= '0;
      pend_len    <= '0;
      pend_status <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_len    <= '0;
      out_status <= '0;
      pend_valid <= 1'b0;
      if (byte_done && !byte_drop && lane == '0 && hold_valid) begin
        out_valid <= 1'b1;
        out_data  <= hold_data;
        out_keep  <= '1;
      end else if (eof && byte_cnt != 16'd0) begin
        if (lane == '0) begin
          // No partial word: the held word is the tail.
          out_valid  <= 1'b1;
          out_data   <= hold_data;
          out_keep   <= '1;
          out_last   <= 1'b1;
          out_len    <= byte_cnt;
          out_status <= fin_status;
        end else if (hold_valid) begin
          // Held word first, partial word follows as the last beat.
          out_valid   <= 1'b1;
          out_data    <= hold_data;
          out_keep    <= '1;
          pend_valid  <= 1'b1;
          pend_data   <= asm_data;
          pend_keep   <= part_keep;
          pend_len    <= byte_cnt;
          pend_status <= fin_status;
        end else begin
          out_valid  <= 1'b1;
          out_data   <= asm_data;
          out_keep   <= part_keep;
          out_last   <= 1'b1;
          out_len    <= byte_cnt;
          out_status <= fin_status;
        end
      end else if (pend_valid) begin
        out_valid  <= 1'b1;
        out_data   <= pend_data;
        out_keep   <= pend_keep;
        out_last   <= 1'b1;
        out_len    <= pend_len;
        out_status <= pend_status;
      end
    end
  end

  generate
    if (CRC_CHECK != 0) begin : g_crc
      logic [31:0] crc_q, crc_next;

      crc32_nib u_crc32_nib (
        .crc_in  (crc_q),
        .nib     (mii_rx_d),
        .crc_out (crc_next)
      );

      // CRC register: seeded on the SFD, advanced on every data nibble.
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)      crc_q <= '0;
        else if (sfd_hit) crc_q <= CRC32_INIT;
        else if (nib_en)  crc_q <= crc_next;
      end

      assign crc_ok = (bit_reverse32(crc_q) == CRC32_RESIDUE);
    end else begin : g_no_crc
      assign crc_ok = 1'b1;
    end
  endgenerate

endmodule
